// File: rtl/bram_line_fetcher_if.sv
// Bus bundle between the line fetcher and its environment (frame BRAM read
// port, line-request pulses from the BRAM counter, SPI tx valid/ready path).
//   read_request_in  : 1-cycle pulse, start fetching the next line
//   hit_max_in       : 1-cycle pulse, line period boundary
//   bram_addr_out    : BRAM read address
//   bram_data_in     : BRAM read data, BRAM latency after the address
//   tx_data_out      : pixel word to the SPI transmitter
//   tx_valid_out     : tx_data_out valid
//   tx_ready_in      : SPI transmitter accepts the word this cycle
//   busy_out         : line transfer in progress
//   overrun_out      : sticky, boundary hit before the line finished
// Modport slave is the fetcher side, master is the environment side.
interface bram_line_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  read_request_in;
    logic                  hit_max_in;
    logic [ADDR_WIDTH-1:0] bram_addr_out;
    logic [DATA_WIDTH-1:0] bram_data_in;
    logic [DATA_WIDTH-1:0] tx_data_out;
    logic                  tx_valid_out;
    logic                  tx_ready_in;
    logic                  busy_out;
    logic                  overrun_out;

    modport slave (
        input  read_request_in,
        input  hit_max_in,
        input  bram_data_in,
        input  tx_ready_in,
        output bram_addr_out,
        output tx_data_out,
        output tx_valid_out,
        output busy_out,
        output overrun_out
    );

    modport master (
        output read_request_in,
        output hit_max_in,
        output bram_data_in,
        output tx_ready_in,
        input  bram_addr_out,
        input  tx_data_out,
        input  tx_valid_out,
        input  busy_out,
        input  overrun_out
    );
endinterface

// File: rtl/bram_line_fetcher.sv
// Streams one line of pixels from frame BRAM into the SPI transmitter on each
// read request. Reads are issued against credits so every in-flight read has
// a guaranteed slot in the small first-word-fall-through output FIFO.
// Ports:
//   clk_in    : system clock
//   rst_n_in  : synchronous reset, active-low
//   bus       : bram_line_fetcher_if.slave (request/boundary pulses,
//               BRAM read port, tx valid/ready, busy and overrun status)
// Optional feature macro: LINE_CHECKSUM_EN -- appends the XOR of all pixels
// of the line as one extra tx word after the last pixel.
// Requires H_PIXELS >= 2, BRAM_LATENCY >= 1, FIFO_DEPTH a power of 2 and
// >= BRAM_LATENCY+1.
module bram_line_fetcher #(
    parameter int unsigned H_PIXELS     = 1280,
    parameter int unsigned V_LINES      = 720,
    parameter int unsigned PIXEL_WIDTH  = 16,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    bram_line_fetcher_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(H_PIXELS * V_LINES);
    localparam int unsigned PIX_W  = $clog2(H_PIXELS);
    localparam int unsigned LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OCC_W  = CNT_W + 1;
    // Stage 0 tracks the read sitting on bram_addr_out, the rest model the
    // BRAM latency; the last stage coincides with valid bram_data_in.
    localparam int unsigned PIPE_N = BRAM_LATENCY + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [PIX_W-1:0]       pix_q, pix_d;
    logic [PIPE_N-1:0]      pipe_q, pipe_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wr_q, rd_q;
    logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                   overrun_q, overrun_d;

    logic                   fifo_nonempty;
    logic                   pop_fifo;
    logic                   push;
    logic [PIXEL_WIDTH-1:0] head;
    logic [OCC_W-1:0]       inflight;
    logic [OCC_W-1:0]       occ;
    logic                   credit_ok;
    logic                   issue;
    logic                   line_done;

`ifdef LINE_CHECKSUM_EN
    logic                   cs_valid_q, cs_valid_d;
    logic [PIXEL_WIDTH-1:0] csum_q, csum_d;
`endif

    assign fifo_nonempty = (count_q != '0);
    assign pop_fifo      = fifo_nonempty & bus.tx_ready_in;
    assign push          = pipe_q[PIPE_N-1];
    assign head          = mem_q[rd_q];

    // Next-state: line FSM, credit-based issue, address and line bookkeeping
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        base_d    = base_q;
        line_d    = line_q;
        pix_d     = pix_q;
        overrun_d = overrun_q;
        issue     = 1'b0;
        line_done = 1'b0;
        inflight  = '0;
`ifdef LINE_CHECKSUM_EN
        cs_valid_d = cs_valid_q;
        csum_d     = csum_q;
        if (pop_fifo) begin
            csum_d = csum_q ^ head;
        end
`endif
        for (int unsigned i = 0; i < PIPE_N; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
        // A word leaving the FIFO this cycle frees its slot for a new read.
        occ       = OCC_W'(count_q) + inflight - OCC_W'(pop_fifo);
        credit_ok = (occ < OCC_W'(FIFO_DEPTH));

        case (state_q)
            S_IDLE: begin
                if (bus.read_request_in) begin
                    issue   = 1'b1;
                    addr_d  = base_q;
                    pix_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    pix_d  = pix_q + PIX_W'(1);
                    if (pix_q == PIX_W'(H_PIXELS - 2)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
`ifdef LINE_CHECKSUM_EN
                if (cs_valid_q) begin
                    if (bus.tx_ready_in) begin
                        cs_valid_d = 1'b0;
                        csum_d     = '0;
                        line_done  = 1'b1;
                    end
                end else if (pipe_q == '0 && count_q == CNT_W'(1) && pop_fifo) begin
                    cs_valid_d = 1'b1;
                end
`else
                if (pipe_q == '0 && count_q == CNT_W'(1) && pop_fifo) begin
                    line_done = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (line_done) begin
            state_d = S_IDLE;
            if (line_q == LINE_W'(V_LINES - 1)) begin
                line_d = '0;
                base_d = '0;
            end else begin
                line_d = line_q + LINE_W'(1);
                base_d = base_q + ADDR_W'(H_PIXELS);
            end
        end

        if (bus.hit_max_in && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        pipe_d  = {pipe_q[PIPE_N-2:0], issue};
        count_d = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
    end

    // State, pipe and FIFO registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            base_q    <= '0;
            line_q    <= '0;
            pix_q     <= '0;
            pipe_q    <= '0;
            count_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef LINE_CHECKSUM_EN
            cs_valid_q <= 1'b0;
            csum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            line_q    <= line_d;
            pix_q     <= pix_d;
            pipe_q    <= pipe_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            if (push) begin
                mem_q[wr_q] <= bus.bram_data_in;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_fifo) begin
                rd_q <= rd_q + PTR_W'(1);
            end
`ifdef LINE_CHECKSUM_EN
            cs_valid_q <= cs_valid_d;
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.bram_addr_out = addr_q;
    assign bus.busy_out      = (state_q != S_IDLE);
    assign bus.overrun_out   = overrun_q;
`ifdef LINE_CHECKSUM_EN
    // Checksum word is only presented once the FIFO has fully drained.
    assign bus.tx_valid_out  = fifo_nonempty | cs_valid_q;
    assign bus.tx_data_out   = cs_valid_q ? csum_q : head;
`else
    assign bus.tx_valid_out  = fifo_nonempty;
    assign bus.tx_data_out   = head;
`endif
endmodule

// File: tb/tb_bram_line_fetcher.sv
// Self-checking bench for bram_line_fetcher: small geometry (8x3), BRAM model
// returning address + offset, scoreboard queue of expected tx words.
module tb_bram_line_fetcher;
    localparam int unsigned H     = 8;
    localparam int unsigned V     = 3;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(H * V);
    localparam int unsigned DW    = 16;
`ifdef LINE_CHECKSUM_EN
    localparam int LINE_WORDS = H + 1;
`else
    localparam int LINE_WORDS = H;
`endif

    logic clk;
    logic rst_n;

    bram_line_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_line_fetcher #(
        .H_PIXELS    (H),
        .V_LINES     (V),
        .PIXEL_WIDTH (DW),
        .BRAM_LATENCY(LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: two register stages, data = address + offset
    logic [DW-1:0] d1, d2;
    int unsigned   data_off;
    always @(posedge clk) begin
        d1 <= DW'(bus.bram_addr_out) + DW'(data_off);
        d2 <= d1;
    end
    assign bus.bram_data_in = d2;

    int n_checks;
    int n_errors;
    int cyc;
    int rmode;        // 0 ready=1, 1 toggle, 2 random, 3 hold 0
    int model_line;
    int line_base_m;
    int acc_cnt;
    int first_word, last_word;
    int first_cyc, last_cyc, idle_cyc;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor and address-lead guard
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (bus.busy_out) begin
            n_checks++;
            if (int'(bus.bram_addr_out) > line_base_m + acc_cnt + 3) begin
                n_errors++;
                $display("FAIL addr_lead: addr %0d exceeds limit %0d", bus.bram_addr_out,
                         line_base_m + acc_cnt + 3);
            end
        end
        if (bus.tx_valid_out && bus.tx_ready_in) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got %0d expected none", bus.tx_data_out);
            end else begin
                w = exp_q.pop_front();
                check("tx_word", 32'(bus.tx_data_out), 32'(w));
            end
            if (acc_cnt == 0) begin
                first_word = int'(bus.tx_data_out);
                first_cyc  = cyc;
            end
            last_word = int'(bus.tx_data_out);
            last_cyc  = cyc;
            acc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.read_request_in = 1'b0;
        bus.hit_max_in      = 1'b0;
        case (rmode)
            0:       bus.tx_ready_in = 1'b1;
            1:       bus.tx_ready_in = ~bus.tx_ready_in;
            2:       bus.tx_ready_in = 1'($urandom_range(0, 1));
            default: bus.tx_ready_in = 1'b0;
        endcase
    endtask

    // Pulse a request and push the line the model expects
    task automatic start_line(input bit with_hit);
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        x = '0;
        line_base_m = model_line * H;
        acc_cnt = 0;
        for (int i = 0; i < H; i++) begin
            w = DW'(line_base_m + i) + DW'(data_off);
            x = x ^ w;
            exp_q.push_back(w);
        end
`ifdef LINE_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        model_line = (model_line + 1) % V;
        bus.read_request_in = 1'b1;
        bus.hit_max_in      = with_hit;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((acc_cnt < LINE_WORDS || bus.busy_out) && n < budget) begin
            tick();
            n++;
        end
        idle_cyc = cyc;
        if (n >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL line_timeout: got %0d words expected %0d", acc_cnt, LINE_WORDS);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},    32'(bus.bram_addr_out), 0);
        check({tag, "_data"},    32'(bus.tx_data_out), 0);
        check({tag, "_valid"},   32'(bus.tx_valid_out), 0);
        check({tag, "_busy"},    32'(bus.busy_out), 0);
        check({tag, "_overrun"}, 32'(bus.overrun_out), 0);
    endtask

    typedef struct {
        int rmode;
        bit hit_with_req;
        int exp_base;
        bit exp_ov;
    } line_vec_t;

    line_vec_t vecs[4];

    initial begin
        int n;
        n_checks = 0; n_errors = 0; cyc = 0; rmode = 0;
        model_line = 0; line_base_m = 0; acc_cnt = 0; data_off = 0;
        first_word = -1; last_word = -1; first_cyc = 0; last_cyc = 0; idle_cyc = 0;
        rst_n = 1'b0;
        bus.read_request_in = 1'b0;
        bus.hit_max_in      = 1'b0;
        bus.tx_ready_in     = 1'b1;

        vecs[0] = '{1, 1'b1, 8,  1'b0};
        vecs[1] = '{2, 1'b0, 16, 1'b0};
        vecs[2] = '{0, 1'b0, 0,  1'b0};
        vecs[3] = '{1, 1'b0, 8,  1'b0};

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Latency, gapless streaming and busy drop on line 0
        rmode = 0;
        start_line(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("latency_valid_low", 32'(bus.tx_valid_out), 0);
        end
        tick();
        check("latency_valid_high", 32'(bus.tx_valid_out), 1);
        wait_done(100);
        check("l0_words", 32'(acc_cnt), 32'(LINE_WORDS));
        check("l0_first", 32'(first_word), 0);
        check("l0_gapless", 32'(last_cyc - first_cyc), 32'(LINE_WORDS - 1));
        check("l0_busy_drop", 32'(idle_cyc - last_cyc), 1);
`ifdef LINE_CHECKSUM_EN
        check("l0_checksum", 32'(last_word), 0);
`endif

        // Table of lines with varied back-pressure, including wrap
        foreach (vecs[v]) begin
            rmode = vecs[v].rmode;
            tick();
            start_line(vecs[v].hit_with_req);
            wait_done(400);
            check("vec_first", 32'(first_word), 32'(vecs[v].exp_base));
            check("vec_words", 32'(acc_cnt), 32'(LINE_WORDS));
            check("vec_overrun", 32'(bus.overrun_out), 32'(vecs[v].exp_ov));
            check("vec_queue_empty", 32'(exp_q.size()), 0);
        end

        // Boundary hit mid-line under back-pressure; request while busy ignored
        rmode = 0;
        tick();
        start_line(1'b0);
        n = 0;
        while (acc_cnt < 3 && n < 50) begin
            tick();
            n++;
        end
        check("ov_reach_word3", 32'(acc_cnt), 3);
        check("ov_before", 32'(bus.overrun_out), 0);
        rmode = 3;
        bus.tx_ready_in = 1'b0;
        bus.hit_max_in  = 1'b1;
        tick();
        check("ov_set", 32'(bus.overrun_out), 1);
        tick();
        bus.read_request_in = 1'b1;
        repeat (8) tick();
        check("ov_hold_no_accept", 32'(acc_cnt), 3);
        rmode = 0;
        wait_done(100);
        check("ov_words", 32'(acc_cnt), 32'(LINE_WORDS));
        check("ov_first", 32'(first_word), 16);
        check("ov_sticky", 32'(bus.overrun_out), 1);
        repeat (6) tick();
        check("ov_req_ignored", 32'(bus.busy_out), 0);
        check("ov_queue_empty", 32'(exp_q.size()), 0);

        // Reset mid-line abandons it; next request restarts at address 0
        tick();
        start_line(1'b0);
        n = 0;
        while (acc_cnt < 5 && n < 50) begin
            tick();
            n++;
        end
        check("rst_reach_word5", 32'(acc_cnt), 5);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        model_line = 0;
        rst_n = 1'b1;
        tick();
        start_line(1'b0);
        wait_done(100);
        check("rst_restart_first", 32'(first_word), 0);
        check("rst_restart_words", 32'(acc_cnt), 32'(LINE_WORDS));

`ifdef LINE_CHECKSUM_EN
        // Line 1 checksum, then data 1..8 on line 0
        tick();
        start_line(1'b0);
        wait_done(100);
        check("cs_line1", 32'(last_word), 0);
        data_off = 1;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        model_line = 0;
        rst_n = 1'b1;
        tick();
        start_line(1'b0);
        wait_done(100);
        check("cs_data1to8", 32'(last_word), 32'h0008);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
